cv32e40p_hwloop_bank: RTL and testbench
=======================================

Name: cv32e40p_hwloop_bank

Overview:
- Parametrised hardware-loop register bank for N_LOOPS nested loops, with configurable address and counter widths.
- Holds start/end/count per loop and detects loop-end PC matches itself.
- Auto-decrements the matching loop, produces the branch-back target, and pulses a per-loop done flag.
- Sits between the ID-stage CSR/hwloop-setup path and the prefetch/PC-mux.

Parameters:
- N_LOOPS, 2, number of hardware loops (1..8); index 0 is the innermost and has highest priority.
- REGID_W, $clog2(N_LOOPS) (min 1), loop-select width.
- ADDR_W, 32, start/end address width.
- CNT_W, 32, iteration counter width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- hwlp_start_data_i  in  ADDR_W  start address write data
- hwlp_end_data_i  in  ADDR_W  end address (last instr of body) write data
- hwlp_cnt_data_i  in  CNT_W  iteration count write data
- hwlp_we_i  in  3  write enables: [0] start, [1] end, [2] count
- hwlp_regid_i  in  REGID_W  target loop for writes
- valid_i  in  1  instruction at hwlp_pc_i retires this cycle
- hwlp_pc_i  in  ADDR_W  PC of retiring instruction
- hwlp_start_addr_o  out  N_LOOPS*ADDR_W  packed start regs, loop k at [k*ADDR_W +: ADDR_W]
- hwlp_end_addr_o  out  N_LOOPS*ADDR_W  packed end regs
- hwlp_counter_o  out  N_LOOPS*CNT_W  packed counters
- hwlp_active_o  out  N_LOOPS  counter[k] != 0
- hwlp_jump_o  out  1  branch back to loop start
- hwlp_target_o  out  ADDR_W  branch target
- hwlp_done_o  out  N_LOOPS  one-cycle registered pulse on final iteration
- hwlp_err_o  out  N_LOOPS  sticky setup error (see Optional Feature)

Behaviour:
- Reset (sync, rst=1 at posedge):
  - All start/end/count regs, done_o and err_o go to 0.
  - Therefore active_o=0 and jump_o=0.
  - Reset wins over every simultaneous write or decrement.
- Writes take effect at the next posedge; readback on the *_o buses follows one cycle later.
  - Start/end data are stored with bit 0 forced to 0.
  - hwlp_regid_i >= N_LOOPS: write ignored.
- Match: match[k] = active[k] && (hwlp_pc_i == end_q[k]). Combinational from regs and PC.
- Selected loop: sel = lowest k with match[k]. Only sel is acted on; outer loops ending on the same PC are untouched.
- Jump (combinational):
  - hwlp_jump_o = valid_i && any match && counter[sel] >= 2.
  - hwlp_target_o = start_q[sel]; 0 when no match.
- Decrement:
  - When valid_i && any match: counter[sel] <= counter[sel] - 1.
  - Never wraps; 0 stays 0 (unreachable via match, since match requires active).
- Done: when counter[sel]==1 and it decrements, done_o[sel] <= 1 for exactly one cycle. No jump that cycle (fall-through).
- Count write and decrement to the same loop in the same cycle: write wins, no done pulse. Other loops still decrement normally.
- Start/end written in the same cycle as a match on that loop:
  - Match uses the old (registered) values.
  - New values apply from the next cycle.
- Writing count=0 disarms the loop immediately in the following cycle.
- Counter arithmetic is CNT_W wide, unsigned. Address compare is full ADDR_W equality.

Optional Feature:
- Macro: CV32E40P_HWLP_ERR_EN.
- Enabled: check on every count write with nonzero data.
  - Effective end = hwlp_end_data_i if we[1] in the same cycle, else end_q; effective start likewise.
  - If effective end < effective start: counter is written 0 (loop not armed) and err_o[id] <= 1.
  - A later passing count write to that loop clears err_o[id]. Reset clears all.
- Disabled: no check, count always written, hwlp_err_o tied to 0.

Decomposition:
- Package cv32e40p_hwloop_pkg holds:
  - the write-enable index constants HWLP_WE_START=0, HWLP_WE_END=1, HWLP_WE_CNT=2;
  - the typedef hwlp_regid_t.
- One sub-module, cv32e40p_hwloop_prio_sel: parametrised lowest-index priority encoder producing the match-valid bit and sel index.
- Per-loop register slices are a generate loop in the top.

Test Plan:
- Reset mid-loop: loop0 start=0x100, end=0x120, cnt=3; assert rst during retire at 0x120 -> all counters 0, no jump, no done next cycle.
- Basic loop: loop0 start=0x100, end=0x120, cnt=3; retire 0x120 three times:
  - counter 3->2->1->0;
  - jump_o=1 with target 0x100 on the first two;
  - third retire gives jump_o=0 and done_o[0] pulses for one cycle.
- Nested same end: loop0 and loop1 both end=0x200 (starts 0x1F0/0x1E0), cnt0=1, cnt1=2; retire 0x200:
  - only loop0 decrements, done_o[0]=1, no jump;
  - next retire at 0x200 -> loop1 jumps to 0x1E0, cnt1=1.
- Write/decrement collision: loop1 cnt=5 matching; same cycle write cnt=9 to loop1 -> counter 9, no decrement, no done.
- Zero count / bad regid: write cnt=0 to loop0 -> active_o[0]=0, no match at end PC; write with regid=3 when N_LOOPS=2 -> no register changes.
- With CV32E40P_HWLP_ERR_EN: start=0x300, end=0x2F0, cnt=4 -> counter 0, err_o[0]=1; rewrite end=0x310 then cnt=4 -> counter 4, err_o[0]=0.

Source files
------------

// File: rtl/cv32e40p_hwloop_pkg.sv
// ----------------------------------------------------------------------------
// cv32e40p_hwloop_pkg
// Shared definitions for the hardware-loop register bank:
//   - bit positions inside the 3-bit hwlp_we_i write-enable vector
//   - hwlp_regid_t, an index wide enough for the largest supported bank (8)
// ----------------------------------------------------------------------------
package cv32e40p_hwloop_pkg;

    localparam int HWLP_WE_START  = 0;
    localparam int HWLP_WE_END    = 1;
    localparam int HWLP_WE_CNT    = 2;

    localparam int HWLP_MAX_LOOPS = 8;

    typedef logic [$clog2(HWLP_MAX_LOOPS)-1:0] hwlp_regid_t;

endpackage

// File: rtl/cv32e40p_hwloop_prio_sel.sv
// ----------------------------------------------------------------------------
// cv32e40p_hwloop_prio_sel
// Lowest-index priority encoder. Index 0 is the innermost loop and wins
// whenever several loops request in the same cycle.
// Ports:
//   req  in   N_LOOPS   per-loop request (match) vector
//   vld  out  1         at least one request is set
//   idx  out  regid     index of the lowest set request (0 when none)
// ----------------------------------------------------------------------------
module cv32e40p_hwloop_prio_sel
    import cv32e40p_hwloop_pkg::*;
#(
    parameter int N_LOOPS = 2
) (
    input  logic [N_LOOPS-1:0] req,
    output logic               vld,
    output hwlp_regid_t        idx
);

    // Scan from the top down so the lowest set index is the last assignment.
    always_comb begin
        vld = 1'b0;
        idx = '0;
        for (int i = N_LOOPS - 1; i >= 0; i--) begin
            if (req[i]) begin
                vld = 1'b1;
                idx = hwlp_regid_t'(i);
            end
        end
    end

endmodule

// File: rtl/cv32e40p_hwloop_bank.sv
// ----------------------------------------------------------------------------
// cv32e40p_hwloop_bank
// Hardware-loop register bank for N_LOOPS nested loops. Holds start/end/count
// per loop, detects the loop-end PC, decrements the innermost matching loop,
// produces the branch-back target and a one-cycle done pulse on the final
// iteration.
//
// Optional feature (macro CV32E40P_HWLP_ERR_EN): a nonzero count write whose
// effective end address lies below its effective start address leaves the
// loop disarmed and raises a sticky per-loop error flag. Without the macro
// no check is made and hwlp_err_o is tied to 0.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   hwlp_start_data_i     start address write data (bit 0 dropped)
//   hwlp_end_data_i       end address write data (bit 0 dropped)
//   hwlp_cnt_data_i       iteration count write data
//   hwlp_we_i             write enables [0] start, [1] end, [2] count
//   hwlp_regid_i          loop targeted by the write (out of range: ignored)
//   valid_i, hwlp_pc_i    retiring instruction and its PC
//   hwlp_start_addr_o     packed start registers, loop k at [k*ADDR_W +: ADDR_W]
//   hwlp_end_addr_o       packed end registers
//   hwlp_counter_o        packed counters, loop k at [k*CNT_W +: CNT_W]
//   hwlp_active_o         counter[k] != 0
//   hwlp_jump_o           branch back to the selected loop's start
//   hwlp_target_o         branch target (0 when no loop matches)
//   hwlp_done_o           one-cycle pulse after the final iteration retires
//   hwlp_err_o            sticky setup error
// ----------------------------------------------------------------------------
module cv32e40p_hwloop_bank
    import cv32e40p_hwloop_pkg::*;
#(
    parameter int N_LOOPS = 2,
    parameter int REGID_W = (N_LOOPS > 1) ? $clog2(N_LOOPS) : 1,
    parameter int ADDR_W  = 32,
    parameter int CNT_W   = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ADDR_W-1:0]          hwlp_start_data_i,
    input  logic [ADDR_W-1:0]          hwlp_end_data_i,
    input  logic [CNT_W-1:0]           hwlp_cnt_data_i,
    input  logic [2:0]                 hwlp_we_i,
    input  logic [REGID_W-1:0]         hwlp_regid_i,
    input  logic                       valid_i,
    input  logic [ADDR_W-1:0]          hwlp_pc_i,
    output logic [N_LOOPS*ADDR_W-1:0]  hwlp_start_addr_o,
    output logic [N_LOOPS*ADDR_W-1:0]  hwlp_end_addr_o,
    output logic [N_LOOPS*CNT_W-1:0]   hwlp_counter_o,
    output logic [N_LOOPS-1:0]         hwlp_active_o,
    output logic                       hwlp_jump_o,
    output logic [ADDR_W-1:0]          hwlp_target_o,
    output logic [N_LOOPS-1:0]         hwlp_done_o,
    output logic [N_LOOPS-1:0]         hwlp_err_o
);

    // Instructions are at least halfword aligned, so bit 0 is never stored.
    localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-1){1'b1}}, 1'b0};

    logic [ADDR_W-1:0] start_q [N_LOOPS];
    logic [ADDR_W-1:0] end_q   [N_LOOPS];
    logic [CNT_W-1:0]  cnt_q   [N_LOOPS];
    logic [N_LOOPS-1:0] done_q;
    logic [N_LOOPS-1:0] err_q;
    logic [N_LOOPS-1:0] active;
    logic [N_LOOPS-1:0] match;

    logic              any_match;
    hwlp_regid_t       sel;
    logic [CNT_W-1:0]  cnt_sel;
    logic [ADDR_W-1:0] start_sel;

    logic [ADDR_W-1:0] start_wdata;
    logic [ADDR_W-1:0] end_wdata;
    logic              cnt_wdata_nz;

    assign start_wdata  = hwlp_start_data_i & ALIGN_MASK;
    assign end_wdata    = hwlp_end_data_i & ALIGN_MASK;
    assign cnt_wdata_nz = (hwlp_cnt_data_i != '0);

    cv32e40p_hwloop_prio_sel #(
        .N_LOOPS (N_LOOPS)
    ) u_prio_sel (
        .req (match),
        .vld (any_match),
        .idx (sel)
    );

    // Mux out the selected loop's counter and start without array indexing,
    // which keeps the select index width independent of N_LOOPS.
    always_comb begin
        cnt_sel   = '0;
        start_sel = '0;
        for (int k = 0; k < N_LOOPS; k++) begin
            if (any_match && (sel == hwlp_regid_t'(k))) begin
                cnt_sel   = cnt_q[k];
                start_sel = start_q[k];
            end
        end
    end

    // With one iteration left the body falls through instead of branching.
    assign hwlp_jump_o   = valid_i && any_match && (cnt_sel > CNT_W'(1));
    assign hwlp_target_o = start_sel;

    for (genvar k = 0; k < N_LOOPS; k++) begin : g_loop
        logic              wr_hit;
        logic              wr_start;
        logic              wr_end;
        logic              wr_cnt;
        logic              dec;
        logic              cnt_bad;
        logic [ADDR_W-1:0] start_r;
        logic [ADDR_W-1:0] end_r;
        logic [CNT_W-1:0]  cnt_r;
        logic              done_r;

        // Out-of-range regids never equal any k, so such writes drop out here.
        assign wr_hit   = (int'(hwlp_regid_i) == k);
        assign wr_start = wr_hit && hwlp_we_i[HWLP_WE_START];
        assign wr_end   = wr_hit && hwlp_we_i[HWLP_WE_END];
        assign wr_cnt   = wr_hit && hwlp_we_i[HWLP_WE_CNT];
        assign dec      = valid_i && any_match && (sel == hwlp_regid_t'(k));

`ifdef CV32E40P_HWLP_ERR_EN
        logic [ADDR_W-1:0] eff_start;
        logic [ADDR_W-1:0] eff_end;
        logic              err_r;

        // Check against the addresses the loop will hold once this write lands.
        assign eff_start = wr_start ? start_wdata : start_r;
        assign eff_end   = wr_end ? end_wdata : end_r;
        assign cnt_bad   = cnt_wdata_nz && (eff_end < eff_start);

        // Zero-count writes are not checked and leave the flag as it was.
        always_ff @(posedge clk) begin
            if (rst) begin
                err_r <= 1'b0;
            end else if (wr_cnt && cnt_wdata_nz) begin
                err_r <= cnt_bad;
            end
        end

        assign err_q[k] = err_r;
`else
        assign cnt_bad  = 1'b0;
        assign err_q[k] = 1'b0;
`endif

        always_ff @(posedge clk) begin
            if (rst) begin
                start_r <= '0;
                end_r   <= '0;
                cnt_r   <= '0;
                done_r  <= 1'b0;
            end else begin
                if (wr_start) begin
                    start_r <= start_wdata;
                end
                if (wr_end) begin
                    end_r <= end_wdata;
                end
                // A count write overrides a same-cycle decrement of this loop.
                if (wr_cnt) begin
                    cnt_r <= cnt_bad ? '0 : hwlp_cnt_data_i;
                end else if (dec && (cnt_r != '0)) begin
                    cnt_r <= cnt_r - CNT_W'(1);
                end
                done_r <= dec && !wr_cnt && (cnt_r == CNT_W'(1));
            end
        end

        assign start_q[k] = start_r;
        assign end_q[k]   = end_r;
        assign cnt_q[k]   = cnt_r;
        assign done_q[k]  = done_r;
        assign active[k]  = (cnt_r != '0);
        assign match[k]   = active[k] && (hwlp_pc_i == end_r);

        assign hwlp_start_addr_o[k*ADDR_W +: ADDR_W] = start_r;
        assign hwlp_end_addr_o[k*ADDR_W +: ADDR_W]   = end_r;
        assign hwlp_counter_o[k*CNT_W +: CNT_W]      = cnt_r;
    end

    assign hwlp_active_o = active;
    assign hwlp_done_o   = done_q;
    assign hwlp_err_o    = err_q;

endmodule

// File: tb/tb_cv32e40p_hwloop_bank.sv
// ----------------------------------------------------------------------------
// tb_cv32e40p_hwloop_bank
// Directed scoreboard bench for cv32e40p_hwloop_bank (N_LOOPS=2, REGID_W=2 so
// that an out-of-range regid of 3 can be driven). Each step drives inputs
// just after a rising edge and pushes the hand-computed outputs expected for
// that cycle; a monitor pops and compares on the falling edge.
// Honours CV32E40P_HWLP_ERR_EN for the setup-error scenarios.
// ----------------------------------------------------------------------------
module tb_cv32e40p_hwloop_bank;

    localparam int N_LOOPS = 2;
    localparam int REGID_W = 2;
    localparam int ADDR_W  = 32;
    localparam int CNT_W   = 32;

`ifdef CV32E40P_HWLP_ERR_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif

    logic                      clk;
    logic                      rst;
    logic [ADDR_W-1:0]         start_data;
    logic [ADDR_W-1:0]         end_data;
    logic [CNT_W-1:0]          cnt_data;
    logic [2:0]                we;
    logic [REGID_W-1:0]        regid;
    logic                      valid;
    logic [ADDR_W-1:0]         pc;
    logic [N_LOOPS*ADDR_W-1:0] start_addr;
    logic [N_LOOPS*ADDR_W-1:0] end_addr;
    logic [N_LOOPS*CNT_W-1:0]  counter;
    logic [N_LOOPS-1:0]        active;
    logic                      jump;
    logic [ADDR_W-1:0]         target;
    logic [N_LOOPS-1:0]        done;
    logic [N_LOOPS-1:0]        err;

    cv32e40p_hwloop_bank #(
        .N_LOOPS (N_LOOPS),
        .REGID_W (REGID_W),
        .ADDR_W  (ADDR_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .hwlp_start_data_i (start_data),
        .hwlp_end_data_i   (end_data),
        .hwlp_cnt_data_i   (cnt_data),
        .hwlp_we_i         (we),
        .hwlp_regid_i      (regid),
        .valid_i           (valid),
        .hwlp_pc_i         (pc),
        .hwlp_start_addr_o (start_addr),
        .hwlp_end_addr_o   (end_addr),
        .hwlp_counter_o    (counter),
        .hwlp_active_o     (active),
        .hwlp_jump_o       (jump),
        .hwlp_target_o     (target),
        .hwlp_done_o       (done),
        .hwlp_err_o        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          step;
        logic        jump;
        logic [31:0] target;
        logic [1:0]  done;
        logic [1:0]  active;
        logic [31:0] cnt0;
        logic [31:0] cnt1;
        logic [1:0]  err;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   step_no = 0;

    task automatic chk(input string nm, input int id, input logic [31:0] got,
                       input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s step %0d: got %h, expected %h", nm, id, got, want);
        end
    endtask

    // Monitor: compare the DUT against the oldest pending expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("jump",   e.step, {31'b0, jump},   {31'b0, e.jump});
            chk("target", e.step, target,          e.target);
            chk("done",   e.step, {30'b0, done},   {30'b0, e.done});
            chk("active", e.step, {30'b0, active}, {30'b0, e.active});
            chk("cnt0",   e.step, counter[31:0],   e.cnt0);
            chk("cnt1",   e.step, counter[63:32],  e.cnt1);
            chk("err",    e.step, {30'b0, err},    {30'b0, e.err});
        end
    end

    task automatic drv(input logic r, input logic [2:0] w, input logic [1:0] id,
                       input logic [31:0] s, input logic [31:0] e, input logic [31:0] c,
                       input logic v, input logic [31:0] p);
        @(posedge clk);
        #1;
        rst        = r;
        we         = w;
        regid      = id;
        start_data = s;
        end_data   = e;
        cnt_data   = c;
        valid      = v;
        pc         = p;
        step_no++;
    endtask

    task automatic expect_out(input logic j, input logic [31:0] t, input logic [1:0] d,
                              input logic [1:0] a, input logic [31:0] c0,
                              input logic [31:0] c1, input logic [1:0] er);
        exp_t e;
        e.step   = step_no;
        e.jump   = j;
        e.target = t;
        e.done   = d;
        e.active = a;
        e.cnt0   = c0;
        e.cnt1   = c1;
        e.err    = er;
        exp_q.push_back(e);
    endtask

    initial begin
        rst = 1'b1; we = '0; regid = '0; start_data = '0; end_data = '0;
        cnt_data = '0; valid = 1'b0; pc = '0;
        repeat (3) @(posedge clk);

        // Reset state, then reset asserted during a retire at the loop end.
        drv(0, 3'b000, 0, 0, 0, 0, 0, 0);             expect_out(0, 0, 0, 0, 0, 0, 0);
        drv(0, 3'b001, 0, 32'h100, 0, 0, 0, 0);       expect_out(0, 0, 0, 0, 0, 0, 0);
        drv(0, 3'b010, 0, 0, 32'h120, 0, 0, 0);       expect_out(0, 0, 0, 0, 0, 0, 0);
        drv(0, 3'b100, 0, 0, 0, 3, 0, 0);             expect_out(0, 0, 0, 0, 0, 0, 0);
        drv(1, 3'b000, 0, 0, 0, 0, 1, 32'h120);       expect_out(1, 32'h100, 0, 2'b01, 3, 0, 0);
        drv(0, 3'b000, 0, 0, 0, 0, 0, 32'h120);       expect_out(0, 0, 0, 0, 0, 0, 0);

        // Basic loop: 3 -> 2 -> 1 -> 0 with fall-through and a done pulse.
        drv(0, 3'b011, 0, 32'h100, 32'h120, 0, 0, 0); expect_out(0, 0, 0, 0, 0, 0, 0);
        drv(0, 3'b100, 0, 0, 0, 3, 0, 0);             expect_out(0, 0, 0, 0, 0, 0, 0);
        drv(0, 3'b000, 0, 0, 0, 0, 1, 32'h120);       expect_out(1, 32'h100, 0, 2'b01, 3, 0, 0);
        drv(0, 3'b000, 0, 0, 0, 0, 1, 32'h120);       expect_out(1, 32'h100, 0, 2'b01, 2, 0, 0);
        drv(0, 3'b000, 0, 0, 0, 0, 1, 32'h120);       expect_out(0, 32'h100, 0, 2'b01, 1, 0, 0);
        drv(0, 3'b000, 0, 0, 0, 0, 0, 32'h120);       expect_out(0, 0, 2'b01, 0, 0, 0, 0);
        drv(0, 3'b000, 0, 0, 0, 0, 0, 0);             expect_out(0, 0, 0, 0, 0, 0, 0);

        // Nested loops sharing end PC 0x200: inner loop takes priority.
        drv(0, 3'b011, 0, 32'h1F0, 32'h200, 0, 0, 0); expect_out(0, 0, 0, 0, 0, 0, 0);
        drv(0, 3'b011, 1, 32'h1E0, 32'h200, 0, 0, 0); expect_out(0, 0, 0, 0, 0, 0, 0);
        drv(0, 3'b100, 0, 0, 0, 1, 0, 0);             expect_out(0, 0, 0, 0, 0, 0, 0);
        drv(0, 3'b100, 1, 0, 0, 2, 0, 0);             expect_out(0, 0, 0, 2'b01, 1, 0, 0);
        drv(0, 3'b000, 0, 0, 0, 0, 0, 32'h200);       expect_out(0, 32'h1F0, 0, 2'b11, 1, 2, 0);
        drv(0, 3'b000, 0, 0, 0, 0, 1, 32'h200);       expect_out(0, 32'h1F0, 0, 2'b11, 1, 2, 0);
        drv(0, 3'b000, 0, 0, 0, 0, 1, 32'h200);       expect_out(1, 32'h1E0, 2'b01, 2'b10, 0, 2, 0);
        drv(0, 3'b000, 0, 0, 0, 0, 0, 0);             expect_out(0, 0, 0, 2'b10, 0, 1, 0);

        // Count write collides with decrement of the same loop: write wins.
        drv(0, 3'b100, 1, 0, 0, 5, 0, 0);             expect_out(0, 0, 0, 2'b10, 0, 1, 0);
        drv(0, 3'b100, 1, 0, 0, 9, 1, 32'h200);       expect_out(1, 32'h1E0, 0, 2'b10, 0, 5, 0);
        drv(0, 3'b000, 0, 0, 0, 0, 0, 0);             expect_out(0, 0, 0, 2'b10, 0, 9, 0);
        drv(0, 3'b100, 1, 0, 0, 1, 0, 0);             expect_out(0, 0, 0, 2'b10, 0, 9, 0);
        drv(0, 3'b100, 1, 0, 0, 2, 1, 32'h200);       expect_out(0, 32'h1E0, 0, 2'b10, 0, 1, 0);
        drv(0, 3'b000, 0, 0, 0, 0, 0, 0);             expect_out(0, 0, 0, 2'b10, 0, 2, 0);

        // Zero count disarms loop 0; regid 3 is out of range and ignored.
        drv(0, 3'b100, 0, 0, 0, 4, 0, 0);             expect_out(0, 0, 0, 2'b10, 0, 2, 0);
        drv(0, 3'b100, 0, 0, 0, 0, 0, 0);             expect_out(0, 0, 0, 2'b11, 4, 2, 0);
        drv(0, 3'b000, 0, 0, 0, 0, 1, 32'h200);       expect_out(1, 32'h1E0, 0, 2'b10, 0, 2, 0);
        drv(0, 3'b111, 3, 32'h400, 32'h404, 7, 0, 0); expect_out(0, 0, 0, 2'b10, 0, 1, 0);
        drv(0, 3'b000, 0, 0, 0, 0, 0, 32'h200);       expect_out(0, 32'h1E0, 0, 2'b10, 0, 1, 0);

        // End below start: rejected with the check, accepted without it.
        drv(0, 3'b011, 0, 32'h300, 32'h2F0, 0, 0, 0); expect_out(0, 0, 0, 2'b10, 0, 1, 0);
        drv(0, 3'b100, 0, 0, 0, 4, 0, 0);             expect_out(0, 0, 0, 2'b10, 0, 1, 0);
        drv(0, 3'b000, 0, 0, 0, 0, 0, 0);
        expect_out(0, 0, 0, ERR_ON ? 2'b10 : 2'b11, ERR_ON ? 32'd0 : 32'd4, 1, ERR_ON ? 2'b01 : 2'b00);
        drv(0, 3'b010, 0, 0, 32'h310, 0, 0, 0);
        expect_out(0, 0, 0, ERR_ON ? 2'b10 : 2'b11, ERR_ON ? 32'd0 : 32'd4, 1, ERR_ON ? 2'b01 : 2'b00);
        drv(0, 3'b100, 0, 0, 0, 4, 0, 0);
        expect_out(0, 0, 0, ERR_ON ? 2'b10 : 2'b11, ERR_ON ? 32'd0 : 32'd4, 1, ERR_ON ? 2'b01 : 2'b00);
        drv(0, 3'b000, 0, 0, 0, 0, 0, 0);             expect_out(0, 0, 0, 2'b11, 4, 1, 0);
        // Same-cycle end write is the one checked.
        drv(0, 3'b110, 0, 0, 32'h2F0, 5, 0, 0);       expect_out(0, 0, 0, 2'b11, 4, 1, 0);
        drv(0, 3'b000, 0, 0, 0, 0, 0, 0);
        expect_out(0, 0, 0, ERR_ON ? 2'b10 : 2'b11, ERR_ON ? 32'd0 : 32'd5, 1, ERR_ON ? 2'b01 : 2'b00);

        // Odd addresses are stored with bit 0 cleared; a good write clears err.
        drv(0, 3'b011, 0, 32'h501, 32'h521, 0, 0, 0);
        expect_out(0, 0, 0, ERR_ON ? 2'b10 : 2'b11, ERR_ON ? 32'd0 : 32'd5, 1, ERR_ON ? 2'b01 : 2'b00);
        drv(0, 3'b100, 0, 0, 0, 2, 0, 0);
        expect_out(0, 0, 0, ERR_ON ? 2'b10 : 2'b11, ERR_ON ? 32'd0 : 32'd5, 1, ERR_ON ? 2'b01 : 2'b00);
        drv(0, 3'b000, 0, 0, 0, 0, 1, 32'h520);       expect_out(1, 32'h500, 0, 2'b11, 2, 1, 0);
        drv(0, 3'b000, 0, 0, 0, 0, 0, 0);             expect_out(0, 0, 0, 2'b11, 1, 1, 0);

        // Let the monitor drain the queue, with a bounded wait.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        tests++;
        if (exp_q.size() > 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
